// File: rtl/conv2_pkg.sv
//== conv2_pkg | shared types and sizing helpers for the conv2 sequencer | rev 1.0
`default_nettype none

package conv2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    REWIND = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int POS_W  = 3;
  localparam int FILT_W = 2;

  function automatic int out_w(input int map_w, input int kernel);
    return map_w - kernel + 1;
  endfunction

  // Must hold the value MAX_OUT itself, not just MAX_OUT-1.
  function automatic int cred_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv2_sched_credit.sv
//== conv2_sched_credit | in-flight window counter with sticky overrun flag | rev 1.0
`default_nettype none

module conv2_sched_credit
  import conv2_pkg::*;
#(
  parameter int MAX_OUT = 8,
  parameter int CW      = cred_w(MAX_OUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          clr_err,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] outstanding,
  output logic          credit_ok,
  output logic          dec_ok,
  output logic          err_overrun
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

  assign credit_ok = (outstanding < MAX_C);
  assign dec_ok    = dec && (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (clr)
        outstanding <= '0;
      else if (inc && !dec_ok)
        outstanding <= outstanding + CW'(1);
      else if (!inc && dec_ok)
        outstanding <= outstanding - CW'(1);

      if (clr_err)
        err_overrun <= 1'b0;
      else if (dec && (outstanding == '0))
        err_overrun <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv2_sched.sv
//== conv2_sched | conv2 window sequencer and result tracker | rev 1.0
//== optional macro CONV2_SCHED_PERF_EN adds perf_cycles / perf_stall outputs
`default_nettype none

module conv2_sched
  import conv2_pkg::*;
#(
  parameter int MAP_W    = 12,
  parameter int KERNEL   = 5,
  parameter int NUM_FILT = 3,
  parameter int MAX_OUT  = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              buf_win_avail,
  output logic              buf_win_pop,
  output logic              buf_rewind,
  output logic [POS_W-1:0]  win_row,
  output logic [POS_W-1:0]  win_col,
  output logic [FILT_W-1:0] filt_sel,
  input  logic              calc_valid,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
`ifdef CONV2_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_stall
`endif
);

  localparam int                OUT_W     = out_w(MAP_W, KERNEL);
  localparam int                CW        = cred_w(MAX_OUT);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(OUT_W - 1);
  localparam logic [FILT_W-1:0] LAST_FILT = FILT_W'(NUM_FILT - 1);

  state_t            state;
  logic [POS_W-1:0]  row, col, hold_row, hold_col;
  logic [FILT_W-1:0] filt, hold_filt;
  logic [CW-1:0]     outstanding;
  logic              credit_ok, dec_ok, issue, start_ok, last_win;

  assign start_ok = (state == IDLE) && start && !abort;
  assign issue    = (state == RUN) && buf_win_avail && credit_ok;
  assign last_win = (row == LAST_POS) && (col == LAST_POS);

  assign buf_win_pop = issue;
  assign buf_rewind  = (state == REWIND);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // Live position while issuing, otherwise the last issued one.
  assign win_row  = issue ? row  : hold_row;
  assign win_col  = issue ? col  : hold_col;
  assign filt_sel = issue ? filt : hold_filt;

  conv2_sched_credit #(
    .MAX_OUT (MAX_OUT),
    .CW      (CW)
  ) u_credit (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (abort || start_ok),
    .clr_err     (start_ok),
    .inc         (issue),
    .dec         (calc_valid && (state != IDLE)),
    .outstanding (outstanding),
    .credit_ok   (credit_ok),
    .dec_ok      (dec_ok),
    .err_overrun (err_overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      filt  <= '0;
    end else if (abort) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      filt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          row   <= '0;
          col   <= '0;
          filt  <= '0;
        end
        RUN: if (issue) begin
          if (last_win)
            state <= (filt == LAST_FILT) ? DRAIN : REWIND;
          else if (col == LAST_POS) begin
            col <= '0;
            row <= row + POS_W'(1);
          end else
            col <= col + POS_W'(1);
        end
        REWIND: begin
          filt  <= filt + FILT_W'(1);
          row   <= '0;
          col   <= '0;
          state <= RUN;
        end
        DRAIN: if (outstanding == '0) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_row  <= '0;
      hold_col  <= '0;
      hold_filt <= '0;
      res_cnt   <= '0;
    end else begin
      if (issue) begin
        hold_row  <= row;
        hold_col  <= col;
        hold_filt <= filt;
      end
      if (start_ok)
        res_cnt <= '0;
      else if (dec_ok)
        res_cnt <= res_cnt + CNT_W'(1);
    end
  end

`ifdef CONV2_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if ((state != IDLE) && !(&perf_cycles))
        perf_cycles <= perf_cycles + CNT_W'(1);
      if ((state == RUN) && buf_win_avail && !credit_ok && !(&perf_stall))
        perf_stall <= perf_stall + CNT_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv2_sched.sv
//== tb_conv2_sched | directed, table-driven bench for conv2_sched | rev 1.0
`default_nettype none

module tb_conv2_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start2 = 1'b0, abort = 1'b0, avail = 1'b0, inj = 1'b0, cv_mode = 1'b0;

  logic       pop1, rew1, busy1, done1, err1, cv1;
  logic [2:0] row1, col1;
  logic [1:0] filt1;
  logic [15:0] res1;
  logic       pop2, rew2, busy2, done2, err2, cv2;
  logic [2:0] row2, col2;
  logic [1:0] filt2;
  logic [15:0] res2;
`ifdef CONV2_SCHED_PERF_EN
  logic [15:0] pc1, ps1, pc2, ps2;
`endif

  logic [7:0] pipe1, pipe2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cv1 = cv_mode ? pipe1[7] : inj;
  assign cv2 = pipe2[7];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe1 <= '0;
      pipe2 <= '0;
    end else begin
      pipe1 <= {pipe1[6:0], pop1};
      pipe2 <= {pipe2[6:0], pop2};
    end
  end

  conv2_sched #(.MAX_OUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .buf_win_avail(avail), .buf_win_pop(pop1), .buf_rewind(rew1),
    .win_row(row1), .win_col(col1), .filt_sel(filt1), .calc_valid(cv1),
    .res_cnt(res1), .busy(busy1), .done(done1), .err_overrun(err1)
`ifdef CONV2_SCHED_PERF_EN
    , .perf_cycles(pc1), .perf_stall(ps1)
`endif
  );

  conv2_sched #(.MAX_OUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort),
    .buf_win_avail(avail), .buf_win_pop(pop2), .buf_rewind(rew2),
    .win_row(row2), .win_col(col2), .filt_sel(filt2), .calc_valid(cv2),
    .res_cnt(res2), .busy(busy2), .done(done2), .err_overrun(err2)
`ifdef CONV2_SCHED_PERF_EN
    , .perf_cycles(pc2), .perf_stall(ps2)
`endif
  );

  // Event monitors, sampled on the falling edge
  logic clr_mon = 1'b0;
  int pops1, rews1, dones1, res_done1, err_done1;
  int pops2, rews2, dones2, res_done2, err_done2, cvs2, cv_done2;
  int out2, max_out2, max_win2, wcnt;
  logic [7:0] win2;

  always @(negedge clk) begin
    if (clr_mon) begin
      pops1 = 0; rews1 = 0; dones1 = 0; res_done1 = -1; err_done1 = -1;
      pops2 = 0; rews2 = 0; dones2 = 0; res_done2 = -1; err_done2 = -1;
      cvs2 = 0; cv_done2 = -1; out2 = 0; max_out2 = 0; max_win2 = 0; win2 = '0;
    end else begin
      if (pop1) pops1++;
      if (rew1) rews1++;
      if (done1) begin dones1++; res_done1 = int'(res1); err_done1 = int'(err1); end
      if (pop2) pops2++;
      if (rew2) rews2++;
      if (cv2) cvs2++;
      if (done2) begin dones2++; res_done2 = int'(res2); err_done2 = int'(err2); cv_done2 = cvs2; end
      out2 = out2 + (pop2 ? 1 : 0) - ((cv2 && out2 > 0) ? 1 : 0);
      if (out2 > max_out2) max_out2 = out2;
      win2 = {win2[6:0], pop2};
      wcnt = $countones(win2);
      if (wcnt > max_win2) max_win2 = wcnt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    clr_mon = 1'b1;
    @(negedge clk);
    #1;
    clr_mon = 1'b0;
  endtask

  typedef struct {
    bit st, ab, av, cv;
    bit e_pop, e_busy, e_done, e_err;
    int e_res;
  } vec_t;

  function automatic vec_t mk(bit st, bit ab, bit av, bit cv,
                              bit p, bit b, bit d, bit e, int r);
    vec_t v;
    v.st = st; v.ab = ab; v.av = av; v.cv = cv;
    v.e_pop = p; v.e_busy = b; v.e_done = d; v.e_err = e; v.e_res = r;
    return v;
  endfunction

  vec_t tbl[30];
  int   n;
  bit   ok;

  initial begin
    // Credit edge, simultaneous issue/result, overrun, busy-start and abort priority
    tbl[0]  = mk(0,0,0,0, 0,0,0,0, 0);
    tbl[1]  = mk(1,0,1,0, 0,0,0,0, 0);
    for (int i = 2; i <= 8; i++) tbl[i] = mk(0,0,1,0, 1,1,0,0, 0);
    tbl[9]  = mk(0,0,1,1, 1,1,0,0, 0);
    tbl[10] = mk(0,0,1,0, 1,1,0,0, 1);
    tbl[11] = mk(0,0,1,0, 0,1,0,0, 1);
    tbl[12] = mk(0,0,1,1, 0,1,0,0, 1);
    tbl[13] = mk(0,0,0,0, 0,1,0,0, 2);
    for (int i = 14; i <= 21; i++) tbl[i] = mk(0,0,0,1, 0,1,0,0, i - 12);
    tbl[22] = mk(0,0,0,0, 0,1,0,1, 9);
    tbl[23] = mk(1,0,0,0, 0,1,0,1, 9);
    tbl[24] = mk(0,1,0,0, 0,1,0,1, 9);
    tbl[25] = mk(1,0,0,0, 0,0,0,1, 9);
    tbl[26] = mk(0,0,0,0, 0,1,0,0, 0);
    tbl[27] = mk(1,1,0,0, 0,1,0,0, 0);
    tbl[28] = mk(1,1,0,0, 0,0,0,0, 0);
    tbl[29] = mk(0,0,0,0, 0,0,0,0, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cv_mode = 1'b0;

    for (int i = 0; i < 30; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; avail = tbl[i].av; inj = tbl[i].cv;
      @(negedge clk);
      chk($sformatf("tbl[%0d].pop", i),  int'(pop1),  int'(tbl[i].e_pop));
      chk($sformatf("tbl[%0d].busy", i), int'(busy1), int'(tbl[i].e_busy));
      chk($sformatf("tbl[%0d].done", i), int'(done1), int'(tbl[i].e_done));
      chk($sformatf("tbl[%0d].err", i),  int'(err1),  int'(tbl[i].e_err));
      chk($sformatf("tbl[%0d].res", i),  int'(res1),  tbl[i].e_res);
      tick;
    end
    start = 0; abort = 0; avail = 0; inj = 0;

    // Continuous frame on both instances (MAX_OUT=8 and MAX_OUT=2)
    cv_mode = 1'b1;
    repeat (10) tick;
    clear_mon;
    start = 1; start2 = 1; avail = 1;
    tick;
    start = 0; start2 = 0;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      tick;
      if (dones1 >= 1 && dones2 >= 1) begin ok = 1; break; end
    end
    chk("frame_timeout", int'(ok), 1);
    avail = 0;
    repeat (20) tick;
    chk("f8.pops", pops1, 192);
    chk("f8.rewinds", rews1, 2);
    chk("f8.dones", dones1, 1);
    chk("f8.res_at_done", res_done1, 192);
    chk("f8.err_at_done", err_done1, 0);
    chk("f2.pops", pops2, 192);
    chk("f2.rewinds", rews2, 2);
    chk("f2.dones", dones2, 1);
    chk("f2.res_at_done", res_done2, 192);
    chk("f2.results_before_done", cv_done2, 192);
    chk("f2.err_at_done", err_done2, 0);
    chk("f2.max_outstanding_le2", int'(max_out2 <= 2), 1);
    chk("f2.max_pops_per8_le2", int'(max_win2 <= 2), 1);

    // Abort after 37 pops, then restart from origin
    clear_mon;
    start = 1; avail = 1;
    tick;
    start = 0;
    n = 0;
    for (int i = 0; i < 200 && n < 37; i++) begin
      @(negedge clk);
      if (pop1) n++;
      if (n < 37) tick;
    end
    chk("abort.pops_reached", n, 37);
    tick;
    avail = 0; abort = 1;
    @(negedge clk);
    chk("abort.hold_row", int'(row1), 4);
    chk("abort.hold_col", int'(col1), 4);
    chk("abort.hold_filt", int'(filt1), 0);
    chk("abort.busy_in_cycle", int'(busy1), 1);
    tick;
    abort = 0;
    @(negedge clk);
    chk("abort.busy_after", int'(busy1), 0);
    chk("abort.done_after", int'(done1), 0);
    repeat (12) tick;
    chk("abort.no_done", dones1, 0);
    start = 1;
    tick;
    start = 0; avail = 1;
    @(negedge clk);
    chk("restart.pop", int'(pop1), 1);
    chk("restart.row", int'(row1), 0);
    chk("restart.col", int'(col1), 0);
    chk("restart.filt", int'(filt1), 0);
    tick;
    @(negedge clk);
    chk("restart.col1", int'(col1), 1);
    tick;
    avail = 0; abort = 1;
    tick;
    abort = 0;
    repeat (12) tick;

    // Asynchronous reset while draining
    clear_mon;
    start = 1; avail = 1;
    tick;
    start = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      tick;
      if (pops1 >= 192) begin ok = 1; break; end
    end
    chk("drain_timeout", int'(ok), 1);
    avail = 0;
    tick;
    chk("pre_rst.busy", int'(busy1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.pop", int'(pop1), 0);
    chk("rst.rewind", int'(rew1), 0);
    chk("rst.row", int'(row1), 0);
    chk("rst.col", int'(col1), 0);
    chk("rst.filt", int'(filt1), 0);
    chk("rst.res", int'(res1), 0);
    chk("rst.busy", int'(busy1), 0);
    chk("rst.done", int'(done1), 0);
    chk("rst.err", int'(err1), 0);
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    clear_mon;
    start = 1; avail = 1;
    tick;
    start = 0;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      tick;
      if (dones1 >= 1) begin ok = 1; break; end
    end
    chk("clean_timeout", int'(ok), 1);
    avail = 0;
    repeat (5) tick;
    chk("clean.pops", pops1, 192);
    chk("clean.rewinds", rews1, 2);
    chk("clean.dones", dones1, 1);
    chk("clean.res_at_done", res_done1, 192);
    chk("clean.err_at_done", err_done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
